// File: rtl/tristate_tx_pkg.sv
// Shared definitions for the tri-state serial transmitter: FSM encoding,
// default turnaround length and a state-decode helper.
package tristate_tx_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRE   = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_TRAIL = 2'd3;

    localparam int TA_DEFAULT = 2;

    // The pad is actively driven only while the preamble or the data bits are on the wire.
    function automatic logic drives_pad(input logic [1:0] st);
        return (st == ST_PRE) || (st == ST_SHIFT);
    endfunction

endpackage

// File: rtl/tristate_tx_shreg.sv
// W-bit load/shift register, MSB first. The MSB output is look-ahead (the MSB
// the register holds after this edge) so the pad flop can register it.
module tristate_tx_shreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic         clear,
    input  logic [W-1:0] data,
    output logic         msb_next
);

    logic [W-1:0] sr_q;
    logic [W-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (clear) begin
            sr_d = '0;
        end else if (load) begin
            sr_d = data;
        end else if (shift) begin
            sr_d = {sr_q[W-2:0], 1'b0};
        end
    end

    assign msb_next = sr_d[W-1];

    // NOTE: sequential state uses non-blocking assignments only; the datapath register is reset like the control flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule

// File: rtl/tristate_tx_seq.sv
// Serial transmitter driving an external tri-state buffer: preamble, MSB-first
// data words with gapless chaining, and a released-bus trailer before idle.
module tristate_tx_seq
    import tristate_tx_pkg::*;
#(
    parameter int W  = 8,
    parameter int TA = TA_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    input  logic         abort,
    output logic         pad_i,
    output logic         pad_t,
    output logic         busy,
    output logic         underrun
);

    localparam int BW  = $clog2(W);
    localparam int TAW = (TA > 0) ? $clog2(TA + 1) : 1;
    localparam logic [BW-1:0]  BIT_MSB  = BW'(W - 1);
    localparam logic [TAW-1:0] TA_LAST  = TAW'((TA > 0) ? TA - 1 : 0);
    localparam logic [1:0]     ST_AFTER = (TA > 0) ? ST_TRAIL : ST_IDLE;

    logic [1:0]     state_q, state_d;
    logic [BW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [TAW-1:0] ta_cnt_q, ta_cnt_d;
    logic           last_q, last_d;
    logic           pad_i_q, pad_i_d;
    logic           pad_t_q, pad_t_d;
    logic           busy_q, busy_d;
    logic           underrun_q, underrun_d;
    logic           sr_load, sr_shift, sr_clear, sr_msb_next;
    logic           xfer;

    // ABORT forces ready low at the chaining point so an abort always beats a new word.
    assign in_ready = (state_q == ST_IDLE) ||
                      ((state_q == ST_SHIFT) && (bit_cnt_q == '0) && !last_q && !abort);
    assign xfer     = in_valid && in_ready;

    tristate_tx_shreg #(.W(W)) u_shreg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (sr_load),
        .shift    (sr_shift),
        .clear    (sr_clear),
        .data     (in_data),
        .msb_next (sr_msb_next)
    );

    // NOTE: every signal assigned here gets a default first, so no latches are inferred.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        ta_cnt_d   = ta_cnt_q;
        last_d     = last_q;
        underrun_d = 1'b0;
        sr_load    = 1'b0;
        sr_shift   = 1'b0;
        sr_clear   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    sr_load   = 1'b1;
                    last_d    = in_last;
                    bit_cnt_d = BIT_MSB;
                    ta_cnt_d  = TA_LAST;
                    state_d   = (TA > 0) ? ST_PRE : ST_SHIFT;
                end
            end
            ST_PRE: begin
                if (abort) begin
                    state_d  = ST_AFTER;
                    ta_cnt_d = TA_LAST;
                    sr_clear = 1'b1;
                end else if (ta_cnt_q == '0) begin
                    state_d = ST_SHIFT;
                end else begin
                    ta_cnt_d = ta_cnt_q - TAW'(1);
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_d  = ST_AFTER;
                    ta_cnt_d = TA_LAST;
                    sr_clear = 1'b1;
                end else if (bit_cnt_q != '0) begin
                    sr_shift  = 1'b1;
                    bit_cnt_d = bit_cnt_q - BW'(1);
                end else if (xfer) begin
                    sr_load   = 1'b1;
                    last_d    = in_last;
                    bit_cnt_d = BIT_MSB;
                end else begin
                    underrun_d = !last_q;
                    state_d    = ST_AFTER;
                    ta_cnt_d   = TA_LAST;
                    sr_clear   = 1'b1;
                end
            end
            ST_TRAIL: begin
                if (ta_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    ta_cnt_d = ta_cnt_q - TAW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        pad_t_d = !drives_pad(state_d);
        pad_i_d = (state_d == ST_SHIFT) ? sr_msb_next : 1'b1;
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            ta_cnt_q   <= '0;
            last_q     <= 1'b0;
            pad_i_q    <= 1'b1;
            pad_t_q    <= 1'b1;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            ta_cnt_q   <= ta_cnt_d;
            last_q     <= last_d;
            pad_i_q    <= pad_i_d;
            pad_t_q    <= pad_t_d;
            busy_q     <= busy_d;
            underrun_q <= underrun_d;
        end
    end

    assign pad_i    = pad_i_q;
    assign pad_t    = pad_t_q;
    assign busy     = busy_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_tristate_tx_seq.sv
// Directed bench for tristate_tx_seq: a W=8/TA=2 instance for the main scenarios
// and a W=8/TA=0 instance for the zero-turnaround latency case.
module tb_tristate_tx_seq;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid, in_last, abort;
    logic       in_ready, pad_i, pad_t, busy, underrun;

    logic [7:0] in_data0;
    logic       in_valid0, in_last0, abort0;
    logic       in_ready0, pad_i0, pad_t0, busy0, underrun0;

    int n_checks;
    int n_fail;

    tristate_tx_seq #(.W(8), .TA(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .abort    (abort),
        .pad_i    (pad_i),
        .pad_t    (pad_t),
        .busy     (busy),
        .underrun (underrun)
    );

    tristate_tx_seq #(.W(8), .TA(0)) dut_ta0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data0),
        .in_valid (in_valid0),
        .in_last  (in_last0),
        .in_ready (in_ready0),
        .abort    (abort0),
        .pad_i    (pad_i0),
        .pad_t    (pad_t0),
        .busy     (busy0),
        .underrun (underrun0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        abort     = 1'b0;
        in_data   = 8'h00;
        in_valid0 = 1'b0;
        in_last0  = 1'b0;
        abort0    = 1'b0;
        in_data0  = 8'h00;
    endtask

    task automatic test_reset();
        logic [4:0] got, exp;
        rst_n = 1'b0;
        idle_inputs();
        #12;
        got = {pad_t, pad_i, in_ready, busy, underrun};
        exp = 5'b11100;
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_ta2 {pad_t,pad_i,in_ready,busy,underrun} got %b want %b", got, exp);
        end
        got = {pad_t0, pad_i0, in_ready0, busy0, underrun0};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_ta0 {pad_t,pad_i,in_ready,busy,underrun} got %b want %b", got, exp);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One LAST word from IDLE: 2 preamble cycles, 8 data bits, 2 trailer cycles, then ready.
    task automatic send_single(input logic [7:0] w, input string tag);
        logic [4:0] got, exp;
        tick();
        in_valid = 1'b1;
        in_data  = w;
        in_last  = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s accept in_ready got %b want 1", tag, in_ready);
        end
        for (int k = 1; k <= 13; k++) begin
            tick();
            idle_inputs();
            @(negedge clk);
            exp[4] = (k <= 10) ? 1'b0 : 1'b1;
            exp[3] = (k >= 3 && k <= 10) ? w[10-k] : 1'b1;
            exp[2] = (k == 13);
            exp[1] = (k <= 12);
            exp[0] = 1'b0;
            got = {pad_t, pad_i, in_ready, busy, underrun};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s k=%0d {pad_t,pad_i,in_ready,busy,underrun} got %b want %b", tag, k, got, exp);
            end
        end
    endtask

    task automatic test_single();
        send_single(8'hA5, "single_a5");
    endtask

    task automatic test_back_to_back();
        logic [4:0] got, exp;
        tick();
        in_valid = 1'b1;
        in_data  = 8'hFF;
        in_last  = 1'b0;
        @(negedge clk);
        for (int k = 1; k <= 21; k++) begin
            tick();
            idle_inputs();
            if (k == 10) begin
                in_valid = 1'b1;
                in_data  = 8'h00;
                in_last  = 1'b1;
            end
            @(negedge clk);
            exp[4] = (k <= 18) ? 1'b0 : 1'b1;
            exp[3] = (k >= 11 && k <= 18) ? 1'b0 : 1'b1;
            exp[2] = (k == 10) || (k == 21);
            exp[1] = (k <= 20);
            exp[0] = 1'b0;
            got = {pad_t, pad_i, in_ready, busy, underrun};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL b2b k=%0d {pad_t,pad_i,in_ready,busy,underrun} got %b want %b", k, got, exp);
            end
        end
    endtask

    task automatic test_underrun();
        logic [4:0] got, exp;
        logic [7:0] w;
        w = 8'h3C;
        tick();
        in_valid = 1'b1;
        in_data  = w;
        in_last  = 1'b0;
        @(negedge clk);
        for (int k = 1; k <= 13; k++) begin
            tick();
            idle_inputs();
            @(negedge clk);
            exp[4] = (k <= 10) ? 1'b0 : 1'b1;
            exp[3] = (k >= 3 && k <= 10) ? w[10-k] : 1'b1;
            exp[2] = (k == 10) || (k == 13);
            exp[1] = (k <= 12);
            exp[0] = (k == 11);
            got = {pad_t, pad_i, in_ready, busy, underrun};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL underrun k=%0d {pad_t,pad_i,in_ready,busy,underrun} got %b want %b", k, got, exp);
            end
        end
    endtask

    task automatic test_abort();
        logic [4:0] got, exp;
        logic [7:0] w;
        w = 8'h81;
        tick();
        in_valid = 1'b1;
        in_data  = w;
        in_last  = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 12; k++) begin
            tick();
            idle_inputs();
            abort = (k == 6);
            @(negedge clk);
            exp[4] = (k <= 6) ? 1'b0 : 1'b1;
            exp[3] = (k >= 3 && k <= 6) ? w[10-k] : 1'b1;
            exp[2] = (k >= 9);
            exp[1] = (k <= 8);
            exp[0] = 1'b0;
            got = {pad_t, pad_i, in_ready, busy, underrun};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL abort k=%0d {pad_t,pad_i,in_ready,busy,underrun} got %b want %b", k, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [4:0] got, exp;
        tick();
        in_valid = 1'b1;
        in_data  = 8'h5A;
        in_last  = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            idle_inputs();
        end
        @(negedge clk);
        n_checks++;
        if ({pad_t, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL rst_mid pre-reset {pad_t,busy} got %b want 01", {pad_t, busy});
        end
        #2;
        rst_n = 1'b0;
        #1;
        got = {pad_t, pad_i, in_ready, busy, underrun};
        exp = 5'b11100;
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL rst_mid async {pad_t,pad_i,in_ready,busy,underrun} got %b want %b", got, exp);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        send_single(8'h01, "after_reset_01");
    endtask

    task automatic test_ta0();
        logic [4:0] got, exp;
        logic [7:0] w;
        w = 8'h80;
        tick();
        in_valid0 = 1'b1;
        in_data0  = w;
        in_last0  = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready0 !== 1'b1) begin
            n_fail++;
            $display("FAIL ta0 accept in_ready got %b want 1", in_ready0);
        end
        for (int k = 1; k <= 9; k++) begin
            tick();
            idle_inputs();
            @(negedge clk);
            exp[4] = (k <= 8) ? 1'b0 : 1'b1;
            exp[3] = (k <= 8) ? w[8-k] : 1'b1;
            exp[2] = (k == 9);
            exp[1] = (k <= 8);
            exp[0] = 1'b0;
            got = {pad_t0, pad_i0, in_ready0, busy0, underrun0};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL ta0 k=%0d {pad_t,pad_i,in_ready,busy,underrun} got %b want %b", k, got, exp);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_underrun();
        test_abort();
        test_reset_mid_shift();
        test_ta0();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
